logic_cell: RTL and testbench

LOGIC_CELL -- requirements
Module: logic_cell

---
 rtl/logic_cell_pkg.sv | 22 ++
 rtl/logic_cell_lut_mux.sv | 13 +
 rtl/logic_cell.sv | 115 +++++++++++
 tb/tb_logic_cell.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_cell_pkg.sv
// logic_cell shared types: FSM states, K limits, config width helper.
// Config width grows by one mode bit when LOGIC_CELL_FF_EN is defined.
package logic_cell_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int K_MIN = 2;
  localparam int K_MAX = 6;

  function automatic int cfg_width(input int k);
`ifdef LOGIC_CELL_FF_EN
    return (1 << k) + 1;
`else
    return 1 << k;
`endif
  endfunction

endpackage

// File: rtl/logic_cell_lut_mux.sv
// lut_mux: K-input lookup, mask bit selected by sel.
// Purely combinational; sel[K-1] is the most significant index bit.
module lut_mux #(
  parameter int K = 4
) (
  input  logic [(1<<K)-1:0] mask,
  input  logic [K-1:0]      sel,
  output logic              out
);

  assign out = mask[sel];

endmodule

// File: rtl/logic_cell.sv
// logic_cell: serially configured K-LUT with optional output register.
// Define LOGIC_CELL_FF_EN to add the mode bit and registered output.
module logic_cell
  import logic_cell_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  output logic         cfg_done,
  input  logic [K-1:0] lut_in,
  input  logic         ff_en,
  output logic         out
);

  localparam int CFG_W = cfg_width(K);
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam int LUT_N = 1 << K;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CFG_W-1:0] cfg_sr_q;
  logic [CFG_W-1:0] cfg_sr_d;
  logic             comb;
  logic             active;

  assign cfg_sr_d = cfg_en ? {cfg_sr_q[CFG_W-2:0], cfg_in}
                           : cfg_sr_q;
  assign cnt_d    = cnt_q + CNT_ONE;
  assign active   = (state_q == ACTIVE);
  assign cfg_out  = cfg_sr_q[CFG_W-1];
  assign cfg_done = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sr_q <= '0;
    end else begin
      cfg_sr_q <= cfg_sr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCONF;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        UNCONF: begin
          if (cfg_en) begin
            state_q <= LOAD;
            cnt_q   <= CNT_ONE;
          end
        end
        LOAD: begin
          if (cfg_en) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_LAST) begin
              state_q <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (cfg_en) begin
            state_q <= LOAD;
            cnt_q   <= CNT_ONE;
          end
        end
        default: begin
          state_q <= UNCONF;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  lut_mux #(
    .K(K)
  ) u_lut (
    .mask(cfg_sr_q[LUT_N-1:0]),
    .sel (lut_in),
    .out (comb)
  );

`ifdef LOGIC_CELL_FF_EN
  logic q_q;
  logic mode;

  assign mode = cfg_sr_q[LUT_N];

  // Entering LOAD wins over a capture so a reload never leaks stale q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (cfg_en && state_q != LOAD) begin
      q_q <= 1'b0;
    end else if (active && ff_en) begin
      q_q <= comb;
    end
  end

  assign out = active & (mode ? q_q : comb);
`else
  logic unused_ff_en;

  assign unused_ff_en = ff_en;
  assign out          = active & comb;
`endif

endmodule

// File: tb/tb_logic_cell.sv
// tb_logic_cell: scoreboard bench for two chained K=3 logic cells.
// Covers both builds; registered-mode checks need LOGIC_CELL_FF_EN.
module tb_logic_cell;

  localparam int K = 3;
`ifdef LOGIC_CELL_FF_EN
  localparam int CW = 9;
`else
  localparam int CW = 8;
`endif

  localparam int S_OUT0  = 0;
  localparam int S_DONE0 = 1;
  localparam int S_COUT0 = 2;
  localparam int S_OUT1  = 3;
  localparam int S_DONE1 = 4;
  localparam int S_COUT1 = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_en = 1'b0;
  logic         cfg_in = 1'b0;
  logic         ff_en = 1'b0;
  logic [K-1:0] lut_in = '0;
  logic         out0, done0, cout0;
  logic         out1, done1, cout1;

  int n_chk = 0;
  int n_pass = 0;

  string tag_q[$];
  int    sig_q[$];
  logic  exp_q[$];

  always #5 clk = ~clk;

  logic_cell #(.K(K)) u0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .cfg_in  (cfg_in),
    .cfg_out (cout0),
    .cfg_done(done0),
    .lut_in  (lut_in),
    .ff_en   (ff_en),
    .out     (out0)
  );

  logic_cell #(.K(K)) u1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .cfg_in  (cout0),
    .cfg_out (cout1),
    .cfg_done(done1),
    .lut_in  (lut_in),
    .ff_en   (ff_en),
    .out     (out1)
  );

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic expect_v(input string tag, input int sig,
                          input logic v);
    tag_q.push_back(tag);
    sig_q.push_back(sig);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    string t;
    int    s;
    logic  e;
    logic  got;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      e = exp_q.pop_front();
      case (s)
        S_OUT0:  got = out0;
        S_DONE0: got = done0;
        S_COUT0: got = cout0;
        S_OUT1:  got = out1;
        S_DONE1: got = done1;
        default: got = cout1;
      endcase
      chk(t, got, e);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1;
    cfg_in = b;
    @(posedge clk);
    #1;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  // Shift CW bits MSB first; cell must stay unconfigured meanwhile.
  task automatic load(input logic [8:0] w);
    for (int i = CW - 1; i >= 0; i--) begin
      shift_bit(w[i]);
      if (i == CW - 1 || i == 1) begin
        expect_v("load_done", S_DONE0, 1'b0);
        expect_v("load_out", S_OUT0, 1'b0);
        sample();
      end
    end
  endtask

  function automatic logic maj3(input logic [2:0] l);
    return (l[0] & l[1]) | (l[0] & l[2]) | (l[1] & l[2]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] wa;
    logic [8:0] wb;

    #2;
    expect_v("rst_out", S_OUT0, 1'b0);
    expect_v("rst_done", S_DONE0, 1'b0);
    expect_v("rst_cout", S_COUT0, 1'b0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    load({1'b0, 8'h96});
    expect_v("xor_done", S_DONE0, 1'b1);
    sample();
    ff_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      lut_in = 3'(v);
      expect_v("xor_out", S_OUT0, ^lut_in);
      sample();
    end

`ifdef LOGIC_CELL_FF_EN
    ff_en = 1'b0;
    load(9'h180);
    ff_en = 1'b1;
    lut_in = 3'b111;
    expect_v("reg_same", S_OUT0, 1'b0);
    expect_v("reg_done", S_DONE0, 1'b1);
    sample();
    expect_v("reg_edge", S_OUT0, 1'b1);
    sample();
    ff_en = 1'b0;
    lut_in = 3'b000;
    repeat (2) begin
      expect_v("reg_hold", S_OUT0, 1'b1);
      sample();
    end
    ff_en = 1'b1;
    expect_v("reg_load0", S_OUT0, 1'b0);
    sample();
`else
    load({1'b0, 8'hE8});
    expect_v("maj_done", S_DONE0, 1'b1);
    sample();
    for (int v = 0; v < 8; v++) begin
      for (int f = 0; f < 2; f++) begin
        ff_en = f[0];
        lut_in = 3'(v);
        expect_v("maj_out", S_OUT0, maj3(lut_in));
        sample();
      end
    end
`endif

    ff_en = 1'b0;
    load({1'b0, 8'hFF});
    lut_in = 3'd5;
    expect_v("ones_out", S_OUT0, 1'b1);
    sample();
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    expect_v("part_cout", S_COUT0, 1'b1);
    expect_v("part_done", S_DONE0, 1'b0);
    sample();
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("arst_out", S_OUT0, 1'b0);
    expect_v("arst_done", S_DONE0, 1'b0);
    expect_v("arst_cout", S_COUT0, 1'b0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    load({1'b0, 8'h01});
    expect_v("eq0_done", S_DONE0, 1'b1);
    sample();
    for (int v = 0; v < 8; v++) begin
      lut_in = 3'(v);
      expect_v("eq0_out", S_OUT0, lut_in == 3'd0);
      sample();
    end

    lut_in = 3'd0;
    load({1'b0, 8'h80});
    expect_v("and_done", S_DONE0, 1'b1);
    sample();
    for (int v = 0; v < 8; v++) begin
      lut_in = 3'(v);
      expect_v("and_out", S_OUT0, &lut_in);
      sample();
    end

    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wa = {1'b0, 8'h96};
    wb = {1'b0, 8'hE8};
    load(wa);
    load(wb);
    expect_v("chain_done0", S_DONE0, 1'b1);
    expect_v("chain_done1", S_DONE1, 1'b1);
    expect_v("chain_cout0", S_COUT0, wb[CW-1]);
    expect_v("chain_cout1", S_COUT1, wa[CW-1]);
    sample();
    for (int v = 0; v < 8; v++) begin
      lut_in = 3'(v);
      expect_v("chain_out0", S_OUT0, maj3(lut_in));
      expect_v("chain_out1", S_OUT1, ^lut_in);
      sample();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
